// File: rtl/usart_rx_word_if.sv
// Processor-facing side of usart_rx_word: assembled word, valid level,
// sticky error bits and the one-cycle acknowledge strobe.
interface usart_rx_word_if;
  logic        ack;
  logic [31:0] dadoUsart;
  logic        dadoPronto;
  logic [1:0]  erro;

  modport master (output ack, input dadoUsart, dadoPronto, erro);
  modport slave  (input ack, output dadoUsart, dadoPronto, erro);
endinterface

// File: rtl/usart_rx_word.sv
// Oversampling serial receiver packing four bytes little-endian into a 32-bit word.
// Frame is 8N1 by default; defining USART_PARITY_EN switches to 8E1.
module usart_rx_word #(
  parameter int DIV = 27
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  usart_rx_word_if.slave bus
);

  // state  | meaning
  // IDLE   | line idle, waiting for a synced 1->0 edge
  // START  | confirming the start bit at mid-bit
  // DATA   | sampling 8 data bits, LSB first
  // PARITY | sampling the even-parity bit
  // STOP   | sampling the stop bit
  // WAIT   | bad frame, waiting for the line to return high
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
  } state_t;

  localparam int TW = $clog2(DIV);

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    sub_cnt_q, sub_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [31:0]   data_q, data_d;
  logic          pronto_q, pronto_d;
  logic [1:0]    erro_q, erro_d;
  logic          tick, mid_bit, bit_end, start_edge;
  logic          byte_ok, byte_bad, word_done, load;

`ifdef USART_PARITY_EN
  logic par_bad;
  assign par_bad = ^{shift_q, rx_sync_q};
`endif

  assign tick       = (tick_cnt_q == TW'(DIV - 1));
  assign mid_bit    = tick && (sub_cnt_q == 4'd7);
  assign bit_end    = tick && (sub_cnt_q == 4'd15);
  assign start_edge = (state_q == S_IDLE) && rx_prev_q && !rx_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_START;
      S_START: if (mid_bit) state_d = rx_sync_q ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_end && bit_cnt_q == 3'd7) begin
`ifdef USART_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef USART_PARITY_EN
      S_PARITY: if (bit_end) state_d = par_bad ? S_WAIT : S_STOP;
`endif
      S_STOP:  if (bit_end) state_d = rx_sync_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (rx_sync_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    if (start_edge) tick_cnt_d = '0;

    sub_cnt_d = tick ? sub_cnt_q + 4'd1 : sub_cnt_q;
    if (state_q == S_IDLE || (state_q == S_START && mid_bit)) sub_cnt_d = '0;

    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (state_q == S_START && mid_bit) bit_cnt_d = '0;
    if (state_q == S_DATA && bit_end) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {rx_sync_q, shift_q[7:1]};
    end

    byte_ok  = (state_q == S_STOP) && bit_end && rx_sync_q;
    byte_bad = (state_q == S_STOP) && bit_end && !rx_sync_q;
`ifdef USART_PARITY_EN
    if (state_q == S_PARITY && bit_end && par_bad) byte_bad = 1'b1;
`endif
    word_done = byte_ok && (idx_q == 2'd3);
    load      = word_done && (!pronto_q || bus.ack);

    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (byte_bad) idx_d = '0;
    if (byte_ok) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    shadow_d[7:0]   = shift_q;
        2'd1:    shadow_d[15:8]  = shift_q;
        2'd2:    shadow_d[23:16] = shift_q;
        default: ;
      endcase
    end

    data_d   = load ? {shift_q, shadow_q} : data_q;
    pronto_d = load ? 1'b1 : (bus.ack ? 1'b0 : pronto_q);

    // Set has priority over an ack in the same cycle so no fault is lost.
    erro_d = bus.ack ? 2'b00 : erro_q;
    if (byte_bad) erro_d[0] = 1'b1;
    if (word_done && pronto_q && !bus.ack) erro_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      tick_cnt_q <= '0;
      sub_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      data_q     <= '0;
      pronto_q   <= 1'b0;
      erro_q     <= 2'b00;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      tick_cnt_q <= tick_cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      pronto_q   <= pronto_d;
      erro_q     <= erro_d;
    end
  end

  assign bus.dadoUsart  = data_q;
  assign bus.dadoPronto = pronto_q;
  assign bus.erro       = erro_q;

endmodule

// File: doc/usart_rx_word.md
# usart_rx_word

Serial receiver that sits directly upstream of the processor's USART input. It oversamples an asynchronous 8-bit serial line, assembles four consecutive bytes little-endian into a 32-bit word, and presents it on `dadoUsart` with a level `dadoPronto` flag. The flag holds until the processor's `controleUsart` strobe acknowledges it. Framing and overrun faults are reported as sticky error bits.

## Interface
- `DIV`, default 27: clk cycles per oversample tick; one bit time = 16 ticks (27 ≈ 50 MHz / 115200 / 16); legal range ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rx`  in  1  serial line; idle high, LSB first.
- `ack`  in  1  one-cycle acknowledge, driven by the processor's `controleUsart`.
- `dadoUsart`  out  32  assembled word; byte 0 in [7:0], byte 3 in [31:24].
- `dadoPronto`  out  1  word valid, level.
- `erro`  out  2  sticky errors: [0] framing (or parity), [1] overrun.

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1.
- Tick counter counts 0..DIV-1 and pulses `tick` at DIV-1. It is forced to 0 on start-edge detection.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: a synced `rx` 1→0 transition goes to START; the tick and sub-bit counters clear.
  - START: after 8 ticks (mid-bit), go to DATA if `rx`=0. If `rx`=1, treat it as a glitch and return to IDLE with no error.
  - DATA: sample every 16 ticks and shift into the byte LSB first. After 8 bits, go to PARITY if the macro is defined, else go to STOP.
  - STOP: sample after 16 ticks.
    - `rx`=1: the byte is valid and the state returns to IDLE.
    - `rx`=0: set `erro[0]`, discard the byte, clear the byte index to 0, and wait for `rx`=1 before entering IDLE.
- Byte index 0..3 selects the lane of a 32-bit shadow register. A valid byte at index 3 completes the word, and the index wraps to 0.
- On word completion:
  - `dadoPronto`=0: load `dadoUsart` from the shadow and set `dadoPronto`.
  - `dadoPronto`=1 and `ack`=0: overrun. Set `erro[1]`, discard the new word, keep the old one.
  - `dadoPronto`=1 and `ack`=1 in the same cycle: load the new word, keep `dadoPronto`=1, no overrun.
- `ack` while `dadoPronto`=1 clears `dadoPronto` and both `erro` bits on the next edge. `ack` while `dadoPronto`=0 clears `erro` only.
- Reset clears the FSM and partial byte/word, and sets IDLE, index 0, `dadoUsart`=0, `dadoPronto`=0, `erro`=0.

## Timing
- Reset values: `dadoUsart`=32'h0, `dadoPronto`=0, `erro`=2'b00.
- Latency:
  - 2 clk synchronizer delay.
  - Bit n sampled at 8+16(n+1) ticks after the start edge.
  - `dadoPronto` rises on the clk edge after the stop-bit sample of byte 3.
  - `erro[0]` rises on the clk edge after a bad stop/parity sample.
- `dadoUsart` is stable for the whole time `dadoPronto`=1. It changes only at a load.
- `ack` is sampled every cycle. A multi-cycle `ack` acts as repeated acks and is harmless.
- Reception continues during `dadoPronto`=1, so there is no back-pressure on the line.
- Async `rst` assertion mid-frame: outputs go to reset values immediately. After deassertion the line must be idle-high before the next start bit is detected.

## Configuration
- `USART_PARITY_EN` defined: frame is 8E1. A PARITY state samples bit 9, 16 ticks after bit 7. If XOR(data, parity) ≠ 0, set `erro[0]` and discard the byte exactly as for a framing error. Stop is sampled 16 ticks after parity.
- Not defined: frame is 8N1. There is no PARITY state, and the stop bit follows bit 7.

## Test plan
All scenarios use DIV=4 (64 clk per bit), macro off unless stated.
- Send 0x78, 0x56, 0x34, 0x12 → `dadoUsart`=32'h12345678 and `dadoPronto`=1 one clk after the 4th stop sample; both hold until `ack`, then `dadoPronto`=0 the next clk.
- Pulse `rx` low for 8 clk, then high → no byte assembled, `erro`=0, FSM back in IDLE; a following 4-byte word is received correctly.
- Send 0x11, 0x22, then 0x33 with stop=0 → `erro[0]`=1, index reset; then 0xAA, 0xBB, 0xCC, 0xDD → `dadoUsart`=32'hDDCCBBAA.
- Send two words (0x01..0x04, 0x05..0x08) without `ack` → `dadoUsart`=32'h04030201, `erro`=2'b10. `ack` → `dadoPronto`=0, `erro`=0. With `ack` coincident with the 2nd completion → `dadoUsart`=32'h08070605, `dadoPronto`=1, `erro`=0.
- Assert `rst` during data bit 3 of byte 2 → all outputs 0 immediately; after release a fresh word 0xCAFEBABE (bytes BE, BA, FE, CA) arrives intact.
- `USART_PARITY_EN` defined: byte 0x01 with parity 0 → `erro[0]`=1 and the byte is dropped. The same byte with parity 1 → accepted and lands in [7:0].
